circ_deshift_buffer: RTL and testbench



---
 rtl/circ_deshift_buffer_if.sv | 20 ++
 rtl/circ_deshift_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_circ_deshift_buffer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/circ_deshift_buffer_if.sv
// ---------------------------------------------------------------------------
// circ_deshift_buffer_if
//   AXI-stream style sample bus feeding the circular de-shift buffer.
//   tdata  : sample (I/Q packed)
//   tvalid : source has a sample
//   tlast  : source marks the last sample of a frame
//   tready : sink accepts the sample this cycle
//   master : upstream source; slave : the buffer.
// ---------------------------------------------------------------------------
interface circ_deshift_buffer_if #(
  parameter int DATA_WIDTH = 36
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/circ_deshift_buffer.sv
// ---------------------------------------------------------------------------
// circ_deshift_buffer
//   Synthesis-path buffer: takes FFT-ordered frames from a sample stream,
//   undoes the half-frame circular shift applied to every odd frame and
//   replays each frame as phase-indexed words for the polyphase filter.
//   Two ping-pong banks let one frame be written while the other is read.
//
// Ports
//   clk, sync_reset : clock, asynchronous active-high reset
//   fft_size        : frame length (power of two, 8..2^PHASE_WIDTH),
//                     latched on the first beat of each frame
//   s_axis          : input sample stream (slave side)
//   phase_o/data_o  : output phase index and sample, qualified by valid_o
//   valid_o         : output valid, no backpressure
//   tlast_err       : sticky, tlast disagreed with the frame count
// ---------------------------------------------------------------------------
module circ_deshift_buffer #(
  parameter int DATA_WIDTH  = 36,
  parameter int PHASE_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic [PHASE_WIDTH:0]   fft_size,
  circ_deshift_buffer_if.slave   s_axis,
  output logic [PHASE_WIDTH-1:0] phase_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   valid_o,
  output logic                   tlast_err
);

  localparam int DEPTH = 1 << PHASE_WIDTH;

  typedef logic [PHASE_WIDTH-1:0] addr_t;
  typedef logic [PHASE_WIDTH:0]   len_t;
  typedef enum logic {S_IDLE, S_READ} state_e;

  state_e                state_q,     state_d;
  logic [1:0]            full_q,      full_d;
  len_t [1:0]            size_q,      size_d;
  logic                  wr_bank_q,   wr_bank_d;
  logic                  rd_bank_q,   rd_bank_d;
  logic                  odd_q,       odd_d;
  addr_t                 wr_cnt_q,    wr_cnt_d;
  addr_t                 rd_cnt_q,    rd_cnt_d;
  addr_t                 rd_mask_q,   rd_mask_d;
  logic                  tlast_err_q, tlast_err_d;
  logic                  rdy_en_q,    rdy_en_d;
  // Read pipeline: address stage then data stage, two cycles like the RAM.
  logic                  rd_vld_q,    rd_vld_d;
  addr_t                 rd_addr_q,   rd_addr_d;
  logic                  rd_sel_q,    rd_sel_d;
  logic                  valid_q,     valid_d;
  addr_t                 phase_q,     phase_d;
  logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  len_t  wr_size;
  addr_t wr_mask, wr_half, wr_addr;
  logic  wr_end, rd_last, rd_issue, accept;

  // Write-side geometry. On the first beat the live fft_size applies, later
  // beats use the size latched for this bank.
  always_comb begin
    wr_size = (wr_cnt_q == '0) ? fft_size : size_q[wr_bank_q];
    wr_mask = wr_size[PHASE_WIDTH-1:0] - addr_t'(1);
    wr_half = wr_size[PHASE_WIDTH:1];
    wr_addr = odd_q ? ((wr_cnt_q + wr_half) & wr_mask) : wr_cnt_q;
    wr_end  = (wr_cnt_q == wr_mask);
  end

  assign rd_last = (state_q == S_READ) && (rd_cnt_q == rd_mask_q);

  // The bank being released this cycle may be refilled on the very next edge:
  // its last read address is captured on that edge, and the first write of a
  // frame lands at 0 or half, never at the old mask, so nothing is clobbered.
  // This keeps tready high for a stream running at full rate.
  assign s_axis.tready = rdy_en_q &
                         (!full_q[wr_bank_q] | (rd_last & (rd_bank_q == wr_bank_q)));
  assign accept        = s_axis.tvalid & s_axis.tready;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    size_d      = size_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    odd_d       = odd_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_mask_d   = rd_mask_q;
    tlast_err_d = tlast_err_q;
    rdy_en_d    = 1'b1;
    rd_issue    = 1'b0;

    // Read FSM
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = S_READ;
          rd_cnt_d  = '0;
          rd_mask_d = size_q[rd_bank_q][PHASE_WIDTH-1:0] - addr_t'(1);
        end
      end
      S_READ: begin
        rd_issue = 1'b1;
        rd_cnt_d = rd_cnt_q + addr_t'(1);
        if (rd_last) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
          rd_cnt_d          = '0;
          // Chain straight into the other bank when it is already waiting.
          if (full_q[!rd_bank_q]) begin
            rd_mask_d = size_q[!rd_bank_q][PHASE_WIDTH-1:0] - addr_t'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Write side; the frame ends on the count alone, tlast is only audited.
    if (accept) begin
      if (wr_cnt_q == '0) size_d[wr_bank_q] = fft_size;
      if (s_axis.tlast != wr_end) tlast_err_d = 1'b1;
      if (wr_end) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        odd_d             = !odd_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + addr_t'(1);
      end
    end

    // Output delay line
    rd_vld_d  = rd_issue;
    rd_addr_d = rd_issue ? rd_cnt_q  : rd_addr_q;
    rd_sel_d  = rd_issue ? rd_bank_q : rd_sel_q;
    valid_d   = rd_vld_q;
    phase_d   = rd_vld_q ? rd_addr_q : phase_q;
    rd_data_d = rd_data_q;
    if (rd_vld_q) rd_data_d = rd_sel_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_q     <= S_IDLE;
      full_q      <= '0;
      size_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      odd_q       <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_mask_q   <= '0;
      tlast_err_q <= 1'b0;
      rdy_en_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_sel_q    <= 1'b0;
      valid_q     <= 1'b0;
      phase_q     <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      size_q      <= size_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      odd_q       <= odd_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_mask_q   <= rd_mask_d;
      tlast_err_q <= tlast_err_d;
      rdy_en_q    <= rdy_en_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      rd_sel_q    <= rd_sel_d;
      valid_q     <= valid_d;
      phase_q     <= phase_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // NOTE: the sample RAMs are not reset; the full flags guarantee a location
  // is written before it is ever read, and a reset port would block RAM mapping.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_bank_q) mem1[wr_addr] <= s_axis.tdata;
      else           mem0[wr_addr] <= s_axis.tdata;
    end
  end

  assign valid_o   = valid_q;
  assign phase_o   = phase_q;
  assign data_o    = rd_data_q;
  assign tlast_err = tlast_err_q;

endmodule

// File: tb/tb_circ_deshift_buffer.sv
// ---------------------------------------------------------------------------
// tb_circ_deshift_buffer
//   Drives frames into circ_deshift_buffer and scores every output word
//   against a frame-level reference model held in a queue.
// ---------------------------------------------------------------------------
module tb_circ_deshift_buffer;
  localparam int DW = 36;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic [PW:0]   fft_size;
  logic [PW-1:0] phase_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          tlast_err;

  circ_deshift_buffer_if #(.DATA_WIDTH(DW)) s_axis ();

  circ_deshift_buffer #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .fft_size   (fft_size),
    .s_axis     (s_axis),
    .phase_o    (phase_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .tlast_err  (tlast_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            phase;
    logic [DW-1:0] data;
  } exp_t;

  int            n_checks = 0;
  int            n_errors = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] frame_buf[$];
  int            frame_len = 0;
  int            frame_idx = 0;
  logic          exp_err   = 1'b0;
  int            stall_cnt = 0;
  int            run_cur   = 0;
  int            max_run   = 0;
  int            out_cnt   = 0;
  logic [DW-1:0] seen [512];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: collect a frame, then list its output words in phase order.
  task automatic model_accept(input logic [DW-1:0] d, input logic last);
    int  half;
    int  idx;
    logic done;
    if (frame_buf.size() == 0) frame_len = int'(fft_size);
    frame_buf.push_back(d);
    done = (frame_buf.size() == frame_len);
    if (last != done) exp_err = 1'b1;
    if (done) begin
      half = frame_len / 2;
      for (int p = 0; p < frame_len; p++) begin
        idx = (frame_idx % 2 == 1) ? (p + half) % frame_len : p;
        exp_q.push_back('{p, frame_buf[idx]});
      end
      frame_buf.delete();
      frame_idx++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    frame_buf.delete();
    frame_idx = 0;
    exp_err   = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    logic rdy;
    int   waits = 0;
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = last;
    forever begin
      @(negedge clk);
      rdy = s_axis.tready;
      @(posedge clk);
      if (rdy) break;
      stall_cnt++;
      waits++;
      if (waits > 4000) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat_accept: tready stuck low for %0d cycles", waits);
        break;
      end
    end
    if (rdy) model_accept(d, last);
    #1;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  // bad_last < 0 : tlast on the final beat; otherwise tlast only on that beat.
  // chg_at >= 0  : fft_size switches to chg_size before that beat.
  task automatic send_frame(input int n, input int base, input bit rnd, input int gap_max,
                            input int bad_last, input int chg_at, input int chg_size);
    logic [63:0]   r;
    logic [DW-1:0] d;
    logic          last;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) fft_size = (PW+1)'(chg_size);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      r    = {$urandom(), $urandom()};
      d    = rnd ? r[DW-1:0] : DW'(base + i);
      last = (bad_last >= 0) ? (i == bad_last) : (i == n - 1);
      send_beat(d, last);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected word per valid output cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sync_reset) begin
      run_cur = 0;
    end else if (valid_o) begin
      run_cur++;
      if (run_cur > max_run) max_run = run_cur;
      out_cnt++;
      seen[phase_o] = data_o;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: phase=%0d data=0x%0h, expected none", phase_o, data_o);
      end else begin
        e = exp_q.pop_front();
        check("phase", 64'(phase_o), 64'(e.phase));
        check("data",  64'(data_o),  64'(e.data));
      end
    end else begin
      run_cur = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int run;
    int mark;
    int sz;

    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    fft_size      = 10'd8;
    sync_reset    = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",     64'(valid_o),       64'd0);
    check("rst_phase",     64'(phase_o),       64'd0);
    check("rst_data",      64'(data_o),        64'd0);
    check("rst_tlast_err", 64'(tlast_err),     64'd0);
    check("rst_tready",    64'(s_axis.tready), 64'd0);
    @(negedge clk);
    sync_reset = 1'b0;
    #1;
    check("tready_pre_edge", 64'(s_axis.tready), 64'd0);
    @(posedge clk);
    #1;
    check("tready_post_edge", 64'(s_axis.tready), 64'd1);

    // Even frame: data 0..7, latency and run length
    send_frame(8, 0, 1'b0, 0, -1, -1, 0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!valid_o && lat < 50);
    check("even_latency", 64'(lat), 64'd3);
    run = 1;
    while (run < 50) begin
      @(posedge clk);
      #1;
      if (!valid_o) break;
      run++;
    end
    check("even_run_len", 64'(run), 64'd8);
    wait_drain();
    check("even_p0", 64'(seen[0]), 64'd0);
    check("even_p7", 64'(seen[7]), 64'd7);

    // Odd frame: data 10..17 comes out shifted by half
    send_frame(8, 10, 1'b0, 0, -1, -1, 0);
    wait_drain();
    check("odd_p0", 64'(seen[0]), 64'd14);
    check("odd_p3", 64'(seen[3]), 64'd17);
    check("odd_p4", 64'(seen[4]), 64'd10);
    check("odd_p7", 64'(seen[7]), 64'd13);
    check("odd_tlast_err", 64'(tlast_err), 64'd0);

    // Continuous stream: 4 frames of 16, no stalls, no output gaps
    fft_size  = 10'd16;
    stall_cnt = 0;
    max_run   = 0;
    mark      = out_cnt;
    for (int f = 0; f < 4; f++) send_frame(16, 0, 1'b1, 0, -1, -1, 0);
    wait_drain();
    check("stream_stalls",    64'(stall_cnt),      64'd0);
    check("stream_outputs",   64'(out_cnt - mark), 64'd64);
    check("stream_max_run",   64'(max_run),        64'd64);
    check("stream_tlast_err", 64'(tlast_err),      64'd0);

    // Size change mid-frame: 8-sample even frame, then 16-sample odd frame
    fft_size = 10'd8;
    mark     = out_cnt;
    send_frame(8, 200, 1'b0, 0, -1, 4, 16);
    send_frame(16, 300, 1'b0, 0, -1, -1, 0);
    wait_drain();
    check("size_outputs", 64'(out_cnt - mark), 64'd24);
    check("size16_p0",    64'(seen[0]),        64'd308);
    check("size16_p8",    64'(seen[8]),        64'd300);
    check("size16_p15",   64'(seen[15]),       64'd307);

    // tlast on beat 5 of an 8-sample frame
    fft_size = 10'd8;
    mark     = out_cnt;
    send_frame(8, 400, 1'b0, 0, 5, -1, 0);
    wait_drain();
    check("tlast_err_set",   64'(tlast_err),      64'(exp_err));
    check("tlast_err_high",  64'(tlast_err),      64'd1);
    check("misalign_outputs", 64'(out_cnt - mark), 64'd8);
    send_frame(8, 0, 1'b1, 0, -1, -1, 0);
    wait_drain();
    check("tlast_err_sticky", 64'(tlast_err), 64'd1);

    // Random sizes with random input gaps (may fill both banks)
    for (int f = 0; f < 6; f++) begin
      sz       = 8 << $urandom_range(0, 3);
      fft_size = (PW+1)'(sz);
      send_frame(sz, 0, 1'b1, 2, -1, -1, 0);
    end
    wait_drain();

    // Largest frame
    fft_size = 10'd512;
    mark     = out_cnt;
    send_frame(512, 0, 1'b1, 0, -1, -1, 0);
    wait_drain();
    check("max_outputs", 64'(out_cnt - mark), 64'd512);

    // Reset while a frame is draining and another is half written
    fft_size = 10'd8;
    send_frame(8, 0, 1'b1, 0, -1, -1, 0);
    for (int i = 0; i < 3; i++) send_beat(DW'(600 + i), 1'b0);
    #3;
    sync_reset = 1'b1;
    model_reset();
    #1;
    check("midrst_valid",     64'(valid_o),       64'd0);
    check("midrst_phase",     64'(phase_o),       64'd0);
    check("midrst_data",      64'(data_o),        64'd0);
    check("midrst_tlast_err", 64'(tlast_err),     64'd0);
    check("midrst_tready",    64'(s_axis.tready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sync_reset = 1'b0;
    mark = out_cnt;
    send_frame(8, 500, 1'b0, 0, -1, -1, 0);
    wait_drain();
    check("postrst_outputs",   64'(out_cnt - mark), 64'd8);
    check("postrst_p0",        64'(seen[0]),        64'd500);
    check("postrst_p7",        64'(seen[7]),        64'd507);
    check("postrst_tlast_err", 64'(tlast_err),      64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
